// File: rtl/bit_serializer_pkg.sv
// ---------------------------------------------------------------------------
// bit_serializer_pkg
// Shared types and constants for the bit_serializer block.
//   ser_state_t   : FSM state encoding (IDLE, SHIFT, PARITY)
//   DEFAULT_WIDTH : default parallel word width
//   cnt_width()   : width of the per-word bit counter
// PARITY is only reachable when BIT_SERIALIZER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // The counter only ever holds values 0..width-1, so $clog2 is enough.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_if
// Parallel-in handshake plus serial-out bundle for bit_serializer.
//   data_in   : parallel word (WIDTH bits)
//   in_valid  : data_in is valid
//   in_ready  : serializer can accept a word this cycle
//   ser_bit   : serial data bit (feeds the detector din)
//   ser_valid : ser_bit carries a data or parity bit
//   busy      : serializer is not idle
// modport master : upstream word source / observer
// modport slave  : the serializer itself
// ---------------------------------------------------------------------------
interface bit_serializer_if
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             busy;

  modport master (
    output data_in, in_valid,
    input  in_ready, ser_bit, ser_valid, busy
  );

  modport slave (
    input  data_in, in_valid,
    output in_ready, ser_bit, ser_valid, busy
  );

endinterface

// File: rtl/bit_serializer_parity_calc.sv
// ---------------------------------------------------------------------------
// ser_parity_calc
// Combinational even-parity generator: o_parity is the XOR of every bit of
// i_word, so the word plus parity always holds an even number of ones.
//   i_word   : word being accepted
//   o_parity : even-parity bit for i_word
// Only instantiated by bit_serializer when BIT_SERIALIZER_PARITY_EN is set.
// ---------------------------------------------------------------------------
module ser_parity_calc
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_word,
  output logic             o_parity
);

  assign o_parity = ^i_word;

endmodule

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial front end for the serial sequence detector. Words are
// accepted over a valid/ready handshake and shifted out one bit per clock on
// ser_bit. Consecutive words stream with no idle gap.
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset
//   bus   : bit_serializer_if.slave (data_in, in_valid, in_ready,
//           ser_bit, ser_valid, busy)
// Parameters: WIDTH (word width, >= 2), MSB_FIRST (1: bit WIDTH-1 first).
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends one even-parity
// bit to every word (frame length WIDTH+1).
// ---------------------------------------------------------------------------
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  bit_serializer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  ser_state_t       r_state, w_nextState;
  logic [WIDTH-1:0] r_shift, w_nextShift;
  logic [CW-1:0]    r_cnt, w_nextCnt;
  logic             r_serBit, w_nextSerBit;
  logic             r_serValid, w_nextSerValid;
  logic             w_inReady;
  logic             w_accept;
  logic             w_lastBit;

  // Bit that is presented first from a given shift-register value.
  function automatic logic headBit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  assign w_lastBit = (r_state == SHIFT) && (r_cnt == '0);
  assign w_accept  = bus.in_valid && w_inReady;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic w_parity;
  logic r_parity;

  ser_parity_calc #(.WIDTH(WIDTH)) u_parityCalc (
    .i_word   (bus.data_in),
    .o_parity (w_parity)
  );

  // Parity is captured with the word so it is stable during the PARITY
  // cycle even if upstream already presents the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= w_parity;
    end
  end

  // The last cycle of a frame is the parity cycle.
  assign w_inReady = (r_state == IDLE) || (r_state == PARITY);
`else
  // The last cycle of a frame is the final data bit.
  assign w_inReady = (r_state == IDLE) || w_lastBit;
`endif

  // Next-state logic. ser_bit/ser_valid are computed from the next state so
  // they can be registered and line up with the state they describe.
  always_comb begin
    w_nextState    = r_state;
    w_nextShift    = r_shift;
    w_nextCnt      = r_cnt;
    w_nextSerBit   = 1'b0;
    w_nextSerValid = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = SHIFT;
          w_nextShift = bus.data_in;
          w_nextCnt   = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        if (!w_lastBit) begin
          w_nextShift = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};
          w_nextCnt   = r_cnt - CW'(1);
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          w_nextState = PARITY;
`else
          if (w_accept) begin
            w_nextShift = bus.data_in;
            w_nextCnt   = CW'(WIDTH - 1);
          end else begin
            w_nextState = IDLE;
            w_nextShift = '0;
            w_nextCnt   = '0;
          end
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (w_accept) begin
          w_nextState = SHIFT;
          w_nextShift = bus.data_in;
          w_nextCnt   = CW'(WIDTH - 1);
        end else begin
          w_nextState = IDLE;
          w_nextShift = '0;
          w_nextCnt   = '0;
        end
      end
`endif
      default: begin
        w_nextState = IDLE;
        w_nextShift = '0;
        w_nextCnt   = '0;
      end
    endcase

    case (w_nextState)
      SHIFT: begin
        w_nextSerValid = 1'b1;
        w_nextSerBit   = headBit(w_nextShift);
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        w_nextSerValid = 1'b1;
        w_nextSerBit   = r_parity;
      end
`endif
      default: begin
        w_nextSerValid = 1'b0;
        w_nextSerBit   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops the line to quiet at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_serBit   <= 1'b0;
      r_serValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_shift    <= w_nextShift;
      r_cnt      <= w_nextCnt;
      r_serBit   <= w_nextSerBit;
      r_serValid <= w_nextSerValid;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.ser_bit   = r_serBit;
  assign bus.ser_valid = r_serValid;
  assign bus.busy      = (r_state != IDLE);

endmodule
